// File: rtl/bench_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bench_vector_sequencer
// Description : Drives pseudo-random stimulus vectors (Galois LFSR) into a
//               combinational benchmark. After a settle delay it compacts each
//               response into a Galois MISR signature.
// Revision    : 1.0 - initial release
// ============================================================================
module bench_vector_sequencer #(
    parameter int               WIDTH  = 32,
    parameter int               CNT_W  = 16,
    parameter int               SETTLE = 2,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(32'h0040_0007)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_patterns,
    output logic [WIDTH-1:0] dut_in,
    input  logic [WIDTH-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] pat_count
);

    // SETTLE is limited to 1..15, so four bits are enough for the wait counter.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] misr_q, misr_d;
    logic [CNT_W-1:0] pat_count_q, pat_count_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;

    // One Galois shift step with the shared feedback polynomial.
    function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= '0;
            misr_q      <= '0;
            pat_count_q <= '0;
            num_q       <= '0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            misr_q      <= misr_d;
            pat_count_q <= pat_count_d;
            num_q       <= num_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Next-state and datapath update. An abort suppresses every register update
    // in its cycle, so signature and pat_count keep their values.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        misr_d      = misr_q;
        pat_count_d = pat_count_q;
        num_d       = num_q;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d = num_patterns;
                    if (num_patterns == '0) begin
                        misr_d      = '0;
                        pat_count_d = '0;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    lfsr_d      = (seed == '0) ? WIDTH'(1) : seed;
                    misr_d      = '0;
                    pat_count_d = '0;
                    wait_cnt_d  = '0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                    if (wait_cnt_q == SETTLE_LAST) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    misr_d      = galois_step(misr_q) ^ dut_out;
                    lfsr_d      = galois_step(lfsr_q);
                    pat_count_d = pat_count_q + CNT_W'(1);
                    if (pat_count_d == num_q) begin
                        state_d = ST_DONE;
                    end else begin
                        wait_cnt_d = '0;
                        state_d    = ST_WAIT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state.
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_WAIT) || (state_q == ST_CAPTURE);
    assign done      = (state_q == ST_DONE);
    assign dut_in    = lfsr_q;
    assign signature = misr_q;
    assign pat_count = pat_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bench_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bench_vector_sequencer
// Description : Directed self-checking bench for bench_vector_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bench_vector_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] seed = '0;
    logic [15:0] num = '0;
    logic [31:0] ext_out = '0;
    logic        loop_mode = 1'b1;
    logic [31:0] dut_in, dut_out, signature;
    logic [15:0] pat_count;
    logic        busy, done;

    // Second instance: narrow counter, SETTLE=1, always in loopback.
    logic        start2 = 1'b0;
    logic        abort2 = 1'b0;
    logic [31:0] seed2 = '0;
    logic [2:0]  num2 = '0;
    logic [31:0] dut_in2, signature2;
    logic [2:0]  pat_count2;
    logic        busy2, done2;

    int total = 0;
    int bad = 0;
    int busy_cyc, done_cnt, done_cyc;
    logic [31:0] vec [0:63];

    assign dut_out = loop_mode ? dut_in : ext_out;

    always #5 clk = ~clk;

    bench_vector_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
        .num_patterns(num), .dut_in(dut_in), .dut_out(dut_out), .busy(busy),
        .done(done), .signature(signature), .pat_count(pat_count)
    );

    bench_vector_sequencer #(.WIDTH(32), .CNT_W(3), .SETTLE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .seed(seed2),
        .num_patterns(num2), .dut_in(dut_in2), .dut_out(dut_in2), .busy(busy2),
        .done(done2), .signature(signature2), .pat_count(pat_count2)
    );

    // Launch a run and observe 40 cycles; optionally pester the DUT mid-run.
    task automatic do_run(input logic [31:0] s, input logic [15:0] n, input bit poke);
        busy_cyc = 0; done_cnt = 0; done_cyc = 0;
        @(negedge clk); seed = s; num = n; start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk); start = 1'b0;
            if (busy) begin busy_cyc++; vec[busy_cyc] = dut_in; end
            if (done) begin done_cnt++; done_cyc = c; end
            if (poke && busy && c >= 3) begin start = 1'b1; num = 16'd1; seed = 32'hdead_beef; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (dut_in !== 32'h0) begin bad++; $display("FAIL rst_dut_in got=%h exp=0", dut_in); end
        total++; if (signature !== 32'h0) begin bad++; $display("FAIL rst_sig got=%h exp=0", signature); end
        total++; if (pat_count !== 16'h0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", pat_count); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loopback;
        loop_mode = 1'b1;
        do_run(32'h1, 16'd3, 1'b0);
        total++; if (vec[2] !== 32'h1) begin bad++; $display("FAIL loop_vec0 got=%h exp=1", vec[2]); end
        total++; if (vec[5] !== 32'h2) begin bad++; $display("FAIL loop_vec1 got=%h exp=2", vec[5]); end
        total++; if (vec[8] !== 32'h4) begin bad++; $display("FAIL loop_vec2 got=%h exp=4", vec[8]); end
        total++; if (signature !== 32'h4) begin bad++; $display("FAIL loop_sig got=%h exp=4", signature); end
        total++; if (pat_count !== 16'd3) begin bad++; $display("FAIL loop_cnt got=%0d exp=3", pat_count); end
        total++; if (busy_cyc != 10) begin bad++; $display("FAIL loop_busy got=%0d exp=10", busy_cyc); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL loop_done_cnt got=%0d exp=1", done_cnt); end
        total++; if (done_cyc != 11) begin bad++; $display("FAIL loop_done_cyc got=%0d exp=11", done_cyc); end
    endtask

    task automatic test_zero_count;
        do_run(32'h55, 16'd0, 1'b0);
        total++; if (done_cyc != 1) begin bad++; $display("FAIL zero_done_cyc got=%0d exp=1", done_cyc); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done_cnt got=%0d exp=1", done_cnt); end
        total++; if (busy_cyc != 0) begin bad++; $display("FAIL zero_busy got=%0d exp=0", busy_cyc); end
        total++; if (signature !== 32'h0) begin bad++; $display("FAIL zero_sig got=%h exp=0", signature); end
        total++; if (pat_count !== 16'h0) begin bad++; $display("FAIL zero_cnt got=%0d exp=0", pat_count); end
    endtask

    task automatic test_seed_zero;
        do_run(32'h0, 16'd1, 1'b0);
        total++; if (vec[2] !== 32'h1) begin bad++; $display("FAIL seed0_vec got=%h exp=1", vec[2]); end
        total++; if (signature !== 32'h1) begin bad++; $display("FAIL seed0_sig got=%h exp=1", signature); end
        total++; if (busy_cyc != 4) begin bad++; $display("FAIL seed0_busy got=%0d exp=4", busy_cyc); end
        total++; if (pat_count !== 16'd1) begin bad++; $display("FAIL seed0_cnt got=%0d exp=1", pat_count); end
    endtask

    task automatic test_lfsr_feedback;
        loop_mode = 1'b0; ext_out = 32'h0;
        do_run(32'h8000_0000, 16'd2, 1'b0);
        total++; if (vec[2] !== 32'h8000_0000) begin bad++; $display("FAIL fb_vec0 got=%h exp=80000000", vec[2]); end
        total++; if (vec[5] !== 32'h0040_0007) begin bad++; $display("FAIL fb_vec1 got=%h exp=00400007", vec[5]); end
        total++; if (signature !== 32'h0) begin bad++; $display("FAIL fb_sig got=%h exp=0", signature); end
        total++; if (pat_count !== 16'd2) begin bad++; $display("FAIL fb_cnt got=%0d exp=2", pat_count); end
        loop_mode = 1'b1;
    endtask

    task automatic test_start_filter;
        do_run(32'h1, 16'd3, 1'b1);
        total++; if (busy_cyc != 10) begin bad++; $display("FAIL filt_busy got=%0d exp=10", busy_cyc); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL filt_done_cnt got=%0d exp=1", done_cnt); end
        total++; if (signature !== 32'h4) begin bad++; $display("FAIL filt_sig got=%h exp=4", signature); end
        total++; if (pat_count !== 16'd3) begin bad++; $display("FAIL filt_cnt got=%0d exp=3", pat_count); end
    endtask

    task automatic test_abort;
        int dcount;
        // Abort in the second WAIT of an N=5 run.
        @(negedge clk); seed = 32'h1; num = 16'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy got=%b exp=1", busy); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        total++; if (pat_count !== 16'd1) begin bad++; $display("FAIL abort_cnt got=%0d exp=1", pat_count); end
        total++; if (signature !== 32'h1) begin bad++; $display("FAIL abort_sig got=%h exp=1", signature); end
        dcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        total++; if (dcount != 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", dcount); end
        // Abort during the first CAPTURE: its update must be dropped.
        @(negedge clk); seed = 32'h1; num = 16'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1; start = 1'b1;
        @(negedge clk); abort = 1'b0; start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abcap_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abcap_done got=%b exp=0", done); end
        total++; if (pat_count !== 16'd0) begin bad++; $display("FAIL abcap_cnt got=%0d exp=0", pat_count); end
        total++; if (signature !== 32'h0) begin bad++; $display("FAIL abcap_sig got=%h exp=0", signature); end
        total++; if (dut_in !== 32'h1) begin bad++; $display("FAIL abcap_lfsr got=%h exp=1", dut_in); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_run;
        int dcount;
        @(negedge clk); seed = 32'h1; num = 16'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (dut_in !== 32'h2) begin bad++; $display("FAIL rmid_pre_vec got=%h exp=2", dut_in); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        total++; if (dut_in !== 32'h0) begin bad++; $display("FAIL rmid_vec got=%h exp=0", dut_in); end
        total++; if (signature !== 32'h0) begin bad++; $display("FAIL rmid_sig got=%h exp=0", signature); end
        total++; if (pat_count !== 16'h0) begin bad++; $display("FAIL rmid_cnt got=%0d exp=0", pat_count); end
        dcount = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        total++; if (dcount != 0) begin bad++; $display("FAIL rmid_done got=%0d exp=0", dcount); end
        do_run(32'h1, 16'd3, 1'b0);
        total++; if (signature !== 32'h4) begin bad++; $display("FAIL rmid_rerun_sig got=%h exp=4", signature); end
        total++; if (busy_cyc != 10) begin bad++; $display("FAIL rmid_rerun_busy got=%0d exp=10", busy_cyc); end
        total++; if (done_cyc != 11) begin bad++; $display("FAIL rmid_rerun_done got=%0d exp=11", done_cyc); end
    endtask

    task automatic test_max_count;
        int b2, d2, dc2;
        b2 = 0; d2 = 0; dc2 = 0;
        @(negedge clk); seed2 = 32'h1; num2 = 3'd7; start2 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk); start2 = 1'b0;
            if (busy2) b2++;
            if (done2) begin d2++; dc2 = c; end
        end
        total++; if (b2 != 15) begin bad++; $display("FAIL max_busy got=%0d exp=15", b2); end
        total++; if (dc2 != 16) begin bad++; $display("FAIL max_done_cyc got=%0d exp=16", dc2); end
        total++; if (d2 != 1) begin bad++; $display("FAIL max_done_cnt got=%0d exp=1", d2); end
        total++; if (pat_count2 !== 3'd7) begin bad++; $display("FAIL max_cnt got=%0d exp=7", pat_count2); end
        total++; if (signature2 !== 32'h40) begin bad++; $display("FAIL max_sig got=%h exp=40", signature2); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_zero_count();
        test_seed_zero();
        test_lfsr_feedback();
        test_start_filter();
        test_abort();
        test_reset_mid_run();
        test_max_count();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
